ternary_mvm_engine: RTL
=======================

# ternary_mvm_engine

Parametrised, bit-serial ternary matrix-vector multiply engine, the successor to the fixed 12x7 tiny ternary top. It holds an OUT_LEN x IN_LEN matrix of 2-bit ternary weights and streams IN_LEN activations LSB-first, one bit-plane per cycle. Each output row's dot product is accumulated at full precision, saturated to BIT_WIDTH signed, and shifted out bit-serially on OUT_LEN lanes. New relative to the previous generation: a valid-qualified load and compute handshake, reload without reset, signed or unsigned activations, saturation, and an explicit output-valid framing signal.

## Interface
- IN_LEN, 12: activation vector length and weight columns; width of in_data.
- OUT_LEN, 7: output rows and output lanes.
- BIT_WIDTH, 8: activation and result bit width; frame length in cycles.
- SIGNED_ACT, 0: 1 = activations are two's complement (MSB plane has weight -2^(BIT_WIDTH-1)); 0 = unsigned.
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  qualifies in_data (load word in LOAD, activation bit-plane in MULT).
- load_req  in  1  in MULT, return to LOAD to accept a new weight matrix.
- in_data  in  IN_LEN  bit i = column i (weight plane or activation bit).
- out_data  out  OUT_LEN  lane r = current result bit of row r.
- out_valid  out  1  out_data carries a result bit.
- out_first  out  1  out_data carries result bit 0 (LSB) of a frame.
- loading  out  1  1 while in LOAD.

## Operation
- States: LOAD, MULT. After reset: LOAD, load count 0, all weights 0, accumulators 0.
- Weight encoding {hi,lo}: 01 = +1, 11 = -1, 00 and 10 = 0.
- LOAD: each cycle with in_valid=1 accepts one word, indexed by k. Row = k>>1; k even writes the lo planes of that row, k odd writes the hi planes; in_data[i] goes to column i. In_valid=0 cycles are ignored, and the count holds. On the edge that accepts word 2*OUT_LEN-1, the engine moves to MULT with bit count 0. Load_req is ignored in LOAD.
- MULT frame: BIT_WIDTH consecutive in_valid=1 cycles. Bit count b runs 0..BIT_WIDTH-1 and carries plane b of all activations.
  - Per row, each cycle: p = Σ_i w[r][i]·in_data[i], range -IN_LEN..+IN_LEN.
  - acc += p<<b. When b=BIT_WIDTH-1 and SIGNED_ACT=1, acc -= p<<b instead.
  - acc width = BIT_WIDTH + clog2(IN_LEN+1) + 1. The accumulator never overflows.
- Frame end (b=BIT_WIDTH-1 accepted): each row result is saturated to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1] and loaded into the output shift register. Accumulators clear and b returns to 0. Back-to-back frames need no idle cycle.
- in_valid=0 mid-frame (b≠0) aborts the frame: accumulators clear, b→0, no result is produced. in_valid=0 at b=0 is idle.
- load_req=1 in MULT: the next state is LOAD with load count 0. The partial frame is discarded. A result already in the output shift register finishes shifting. Weights are overwritten only as new words arrive.
- load_req and the last bit of a frame in the same cycle: the frame completes, its result is output, and the engine then enters LOAD.
- rst_n=0 at any time: everything returns to reset values on that edge, including an in-progress output shift, which is dropped.

## Timing
- Reset values: out_data=0, out_valid=0, out_first=0, loading=1.
- Latency: the result loads on the edge that accepts the last bit-plane. Result bit j appears on out_data in the j-th cycle after that edge (j=0..BIT_WIDTH-1), LSB first, with out_valid=1 for those BIT_WIDTH cycles.
- out_first=1 only in the j=0 cycle.
- When frames run back to back, the output stream of frame n exactly overlaps input frame n+1, and out_valid stays continuously high.
- out_data=0 whenever out_valid=0.
- Weight load of the full matrix: minimum 2*OUT_LEN cycles. loading falls the cycle after the last word is accepted.

## Test plan
- Defaults, row 0 all +1, row 1 all -1, rows 2-6 zero; frame with all x=10 -> lanes 0/1/2 serialise 0x78 / 0x88 / 0x00, out_first on the first bit, out_valid for 8 cycles.
- Saturation: row 0 +1, row 1 -1, x=127, SIGNED_ACT=0 -> 0x7F and 0x80.
- SIGNED_ACT=1, row 0 +1, x=-3 -> 0xDC. The same stimulus with SIGNED_ACT=0 (x=253) saturates to 0x7F.
- Load with in_valid gaps (toggle every other cycle) -> identical weights and results to a gapless load. loading drops after exactly 14 accepted words.
- Drop in_valid at b=4, then run a full frame with x=1 -> only one result emitted, equal to the row sums. Back-to-back frames keep out_valid high continuously.
- Assert load_req mid-frame while a prior result is shifting -> the shift completes, loading=1, and results after the new load reflect the new weights. rst_n=0 mid-shift -> out_valid=0 next cycle, all weights zero.

Source files
------------

// File: rtl/ternary_mvm_engine_if.sv
// Load/compute handshake and bit-serial result bus of the ternary MVM engine.
// The master drives weight words and activation bit-planes; the slave (the
// engine) returns one result bit per row per cycle with framing flags.
interface ternary_mvm_engine_if #(
  parameter int IN_LEN  = 12,
  parameter int OUT_LEN = 7
);
  logic               in_valid;
  logic               load_req;
  logic [IN_LEN-1:0]  in_data;
  logic [OUT_LEN-1:0] out_data;
  logic               out_valid;
  logic               out_first;
  logic               loading;

  modport master (
    output in_valid, load_req, in_data,
    input  out_data, out_valid, out_first, loading
  );

  modport slave (
    input  in_valid, load_req, in_data,
    output out_data, out_valid, out_first, loading
  );
endinterface

// File: rtl/ternary_mvm_engine.sv
// Bit-serial ternary matrix-vector multiply engine.
// Holds an OUT_LEN x IN_LEN matrix of {hi,lo} ternary weights, accumulates
// each row's dot product over BIT_WIDTH activation bit-planes (LSB first),
// saturates to BIT_WIDTH signed and shifts results out LSB first per row.
module ternary_mvm_engine #(
  parameter int IN_LEN     = 12,
  parameter int OUT_LEN    = 7,
  parameter int BIT_WIDTH  = 8,
  parameter int SIGNED_ACT = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  ternary_mvm_engine_if.slave  bus
);

  // Per-cycle partial sum spans -IN_LEN..+IN_LEN.
  localparam int PW    = $clog2(IN_LEN + 1) + 1;
  localparam int ACC_W = BIT_WIDTH + $clog2(IN_LEN + 1) + 1;
  localparam int LCW   = $clog2(2 * OUT_LEN);
  localparam int BCW   = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

  localparam logic [LCW-1:0] LOAD_LAST = LCW'(2 * OUT_LEN - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_WIDTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {ST_LOAD, ST_MULT} state_t;

  state_t state, state_next;

  logic [LCW-1:0]            load_cnt;
  logic [BCW-1:0]            bit_cnt;
  logic [IN_LEN-1:0]         w_lo     [OUT_LEN];
  logic [IN_LEN-1:0]         w_hi     [OUT_LEN];
  logic signed [ACC_W-1:0]   acc      [OUT_LEN];
  logic signed [ACC_W-1:0]   acc_next [OUT_LEN];
  logic signed [PW-1:0]      psum     [OUT_LEN];
  logic [BIT_WIDTH-1:0]      result   [OUT_LEN];
  logic [BIT_WIDTH-1:0]      out_sr   [OUT_LEN];
  logic                      out_busy;
  logic [BCW-1:0]            out_cnt;

  logic load_word, load_done, plane_ok, last_plane, frame_done;

  // Qualified events for this cycle.
  always_comb begin
    load_word  = (state == ST_LOAD) && bus.in_valid;
    load_done  = load_word && (load_cnt == LOAD_LAST);
    plane_ok   = (state == ST_MULT) && bus.in_valid;
    last_plane = (bit_cnt == BIT_LAST);
    frame_done = plane_ok && last_plane;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers sample
    // the same pre-edge values regardless of statement order.
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_next;
  end

  // Next-state logic: a full matrix enters MULT, load_req returns to LOAD.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a variable
    // unassigned, which would infer a latch.
    state_next = state;
    case (state)
      ST_LOAD: if (load_done)    state_next = ST_MULT;
      ST_MULT: if (bus.load_req) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  // Ternary partial sum per row: lo marks a non-zero weight, hi its sign.
  always_comb begin
    for (int r = 0; r < OUT_LEN; r++) begin
      psum[r] = '0;
      for (int i = 0; i < IN_LEN; i++) begin
        if (w_lo[r][i] && bus.in_data[i])
          psum[r] = w_hi[r][i] ? psum[r] - PW'(1) : psum[r] + PW'(1);
      end
    end
  end

  // Weighted accumulate (MSB plane negative for signed activations) and saturation.
  always_comb begin
    logic signed [ACC_W-1:0] term;
    term = '0;
    for (int r = 0; r < OUT_LEN; r++) begin
      term = {{(ACC_W - PW){psum[r][PW-1]}}, psum[r]};
      term = term <<< bit_cnt;
      if ((SIGNED_ACT != 0) && last_plane) acc_next[r] = acc[r] - term;
      else                                 acc_next[r] = acc[r] + term;
      if (acc_next[r] > SAT_MAX)      result[r] = SAT_MAX[BIT_WIDTH-1:0];
      else if (acc_next[r] < SAT_MIN) result[r] = SAT_MIN[BIT_WIDTH-1:0];
      else                            result[r] = acc_next[r][BIT_WIDTH-1:0];
    end
  end

  // Weight load, bit-plane counter and accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt <= '0;
      bit_cnt  <= '0;
      // NOTE: the weight store is deliberately reset: a fresh engine must
      // compute with an all-zero matrix, not whatever powered up.
      for (int r = 0; r < OUT_LEN; r++) begin
        w_lo[r] <= '0;
        w_hi[r] <= '0;
        acc[r]  <= '0;
      end
    end else begin
      if (load_word) begin
        for (int r = 0; r < OUT_LEN; r++) begin
          if (int'(load_cnt[LCW-1:1]) == r) begin
            if (load_cnt[0]) w_hi[r] <= bus.in_data;
            else             w_lo[r] <= bus.in_data;
          end
        end
        load_cnt <= load_done ? '0 : load_cnt + 1'b1;
      end
      // Accumulate mid-frame; frame end, abort and load_req all clear.
      if (plane_ok && !last_plane && !bus.load_req) begin
        for (int r = 0; r < OUT_LEN; r++) acc[r] <= acc_next[r];
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state == ST_MULT) begin
        for (int r = 0; r < OUT_LEN; r++) acc[r] <= '0;
        bit_cnt <= '0;
      end
    end
  end

  // Output shift register: a completed frame reloads it, else it shifts out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_busy <= 1'b0;
      out_cnt  <= '0;
      for (int r = 0; r < OUT_LEN; r++) out_sr[r] <= '0;
    end else if (frame_done) begin
      out_busy <= 1'b1;
      out_cnt  <= '0;
      for (int r = 0; r < OUT_LEN; r++) out_sr[r] <= result[r];
    end else if (out_busy) begin
      for (int r = 0; r < OUT_LEN; r++) out_sr[r] <= out_sr[r] >> 1;
      if (out_cnt == BIT_LAST) begin
        out_busy <= 1'b0;
        out_cnt  <= '0;
      end else begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Output bus, forced to zero whenever no result bit is present.
  always_comb begin
    bus.loading   = (state == ST_LOAD);
    bus.out_valid = out_busy;
    bus.out_first = out_busy && (out_cnt == '0);
    bus.out_data  = '0;
    for (int r = 0; r < OUT_LEN; r++) bus.out_data[r] = out_busy & out_sr[r][0];
  end

endmodule
